main_memory_burst: RTL and testbench

- Main-memory responder at the far end of the L2 ↔ memory interface.
- Accepts a line request (address plus we_mem) from the L2 controller and waits a fixed access latency.
- Then transfers an 8-word burst over the shared bidirectional data_mem bus, one word per stb edge (rising and falling both count).
- Read: memory drives the bus. Write: memory samples the bus.

---
 rtl/mem_bus_pkg.sv | 30 +++
 rtl/mem_array.sv | 32 +++
 rtl/main_memory_burst.sv | 142 ++++++++++++++
 tb/tb_main_memory_burst.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_bus_pkg
// Brief   : Shared types, constants and address helper for the L2/memory bus.
// Revision: 1.0
// ============================================================================
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic MEM_RD = 1'b1;
    localparam logic MEM_WR = 1'b0;
    localparam int   BEATS  = 8;

    // Word index of the first beat of the line holding byte_addr; wraps at depth.
    function automatic int unsigned line_base(input logic [63:0] byte_addr,
                                              input int unsigned depth,
                                              input int unsigned beats);
        logic [63:0] w_idx;
        w_idx = (byte_addr >> 2) % 64'(depth);
        return 32'(w_idx) & ~(beats - 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
// Module  : mem_array
// Brief   : DEPTH x DATA_W backing store, synchronous write, combinational read.
// Revision: 1.0
// ============================================================================
module mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic [DATA_W-1:0] o_rd_data
);

    // Contents deliberately survive reset; r_mem is also the peek point for benches.
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/main_memory_burst.sv
`default_nettype none
// ============================================================================
// Module  : main_memory_burst
// Brief   : Fixed-latency main-memory responder moving 8-word bursts over a
//           shared tristate bus, one word per stb toggle.
// Revision: 1.0
// ============================================================================
module main_memory_burst #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int BEATS  = mem_bus_pkg::BEATS,
    parameter int DEPTH  = 4096,
    parameter int LAT    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we_mem,
    input  logic [ADDR_W-1:0] addr_mem,
    inout  wire  [DATA_W-1:0] data_mem,
    output logic              stb,
    output logic              busy,
    output logic              done
);
    import mem_bus_pkg::*;

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int BEAT_W = $clog2(BEATS);
    localparam int CNT_W  = (LAT > 1) ? $clog2(LAT) : 1;

    state_t              r_state;
    logic [CNT_W-1:0]    r_lat;
    logic [BEAT_W-1:0]   r_beat;
    logic                r_phase;
    logic                r_tail;
    logic                r_rw;
    logic [IDX_W-1:0]    r_base;
    logic                r_stb;
    logic                r_busy;
    logic                r_done;
    logic                r_drv;
    logic [DATA_W-1:0]   r_dout;

    logic [IDX_W-1:0]    w_idx;
    logic [IDX_W-1:0]    w_req_base;
    logic [DATA_W-1:0]   w_rd_data;
    logic                w_wr_en;

    assign w_req_base = IDX_W'(line_base(64'(addr_mem), DEPTH, BEATS));
    assign w_idx      = r_base + IDX_W'(r_beat);

    // Write samples the bus on the same edge that toggles stb (phase B).
    assign w_wr_en = !rst && (r_state == XFER) && r_phase && !r_tail && (r_rw == MEM_WR);

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk       (clk),
        .i_we      (w_wr_en),
        .i_wr_idx  (w_idx),
        .i_wr_data (data_mem),
        .i_rd_idx  (w_idx),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_lat   <= '0;
            r_beat  <= '0;
            r_phase <= 1'b0;
            r_tail  <= 1'b0;
            r_stb   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_drv   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (req) begin
                        r_state <= WAIT;
                        r_rw    <= we_mem;
                        r_base  <= w_req_base;
                        r_lat   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (r_lat == CNT_W'(LAT - 1)) begin
                        r_state <= XFER;
                        r_beat  <= '0;
                        r_phase <= 1'b0;
                        r_tail  <= 1'b0;
                    end else begin
                        r_lat <= r_lat + CNT_W'(1);
                    end
                end
                XFER: begin
                    // The tail cycle keeps the final read word on the bus after its toggle.
                    if (r_tail) begin
                        r_state <= DONE;
                        r_tail  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_drv   <= 1'b0;
                    end else if (!r_phase) begin
                        r_phase <= 1'b1;
                        if (r_rw == MEM_RD) begin
                            r_drv  <= 1'b1;
                            r_dout <= w_rd_data;
                        end
                    end else begin
                        r_stb   <= ~r_stb;
                        r_phase <= 1'b0;
                        if (r_beat == BEAT_W'(BEATS - 1)) begin
                            r_tail <= 1'b1;
                        end else begin
                            r_beat <= r_beat + BEAT_W'(1);
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign data_mem = r_drv ? r_dout : {DATA_W{1'bz}};
    assign stb      = r_stb;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_main_memory_burst.sv
`default_nettype none
// ============================================================================
// Module  : tb_main_memory_burst
// Brief   : Self-checking bench for main_memory_burst against a timeline model.
// Revision: 1.0
// ============================================================================
module tb_main_memory_burst;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int BEATS  = 8;
    localparam int DEPTH  = 4096;
    localparam int LAT    = 4;
    localparam int D      = LAT + 1 + 2 * BEATS;   // cycle index of the done pulse
    localparam logic [31:0] REL = 32'hFFFF_FFFF;   // released bus reads high via tri1

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req = 1'b0;
    logic              we_mem = 1'b0;
    logic [ADDR_W-1:0] addr_mem = '0;
    tri1  [DATA_W-1:0] data_mem;
    logic              stb;
    logic              busy;
    logic              done;

    logic              tb_drv = 1'b0;
    logic [31:0]       tb_dout = '0;
    assign data_mem = tb_drv ? tb_dout : {DATA_W{1'bz}};

    int          vectors = 0;
    int          miscompares = 0;
    int          ntog;
    logic [31:0] mdl  [DEPTH];
    logic [31:0] wbuf [BEATS];

    always #5 clk = ~clk;

    main_memory_burst #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BEATS  (BEATS),
        .DEPTH  (DEPTH),
        .LAT    (LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .we_mem   (we_mem),
        .addr_mem (addr_mem),
        .data_mem (data_mem),
        .stb      (stb),
        .busy     (busy),
        .done     (done)
    );

    function automatic int base_of(input logic [31:0] a);
        return int'(((a >> 2) % DEPTH) & ~(BEATS - 1));
    endfunction

    // One request; checks busy/done/stb/bus each cycle against the spec timeline.
    task automatic burst(input logic rw, input logic [31:0] addr, input int rst_at, input logic hold);
        int          base;
        int          w;
        int          tog;
        logic        s0;
        logic        prev;
        logic [31:0] exp_bus;
        base = base_of(addr);
        w = 0;
        req = 1'b1; we_mem = rw; addr_mem = addr;
        if (!rw) begin tb_drv = 1'b1; tb_dout = wbuf[0]; end
        @(posedge clk);
        @(negedge clk);
        if (!hold) begin req = 1'b0; we_mem = 1'($urandom); addr_mem = $urandom; end
        s0 = stb; prev = stb;
        for (int n = 0; n <= D; n++) begin
            if (n == rst_at) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                vectors++; if (stb !== 1'b0) begin miscompares++; $display("FAIL rst_mid_stb got %b want 0", stb); end
                vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy got %b want 0", busy); end
                vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_mid_done got %b want 0", done); end
                vectors++; if (data_mem !== REL) begin miscompares++; $display("FAIL rst_mid_bus got %h want released", data_mem); end
                for (int c = 0; c < 30; c++) begin
                    @(negedge clk);
                    vectors++;
                    if (done !== 1'b0 || busy !== 1'b0) begin
                        miscompares++; $display("FAIL rst_mid_after c=%0d got busy=%b done=%b want 0 0", c, busy, done);
                    end
                end
                return;
            end
            tog = (n >= LAT + 2) ? ((n - LAT - 2) / 2 + 1) : 0;
            if (tog > BEATS) tog = BEATS;
            vectors++; if (busy !== (n < D)) begin miscompares++; $display("FAIL busy n=%0d got %b want %b", n, busy, (n < D)); end
            vectors++; if (done !== (n == D)) begin miscompares++; $display("FAIL done n=%0d got %b want %b", n, done, (n == D)); end
            vectors++; if (stb !== (s0 ^ tog[0])) begin miscompares++; $display("FAIL stb n=%0d got %b want %b", n, stb, s0 ^ tog[0]); end
            if (stb !== prev) ntog++;
            if (rw) begin
                exp_bus = (n >= LAT + 1 && n <= LAT + 2 * BEATS) ? mdl[base + (n - LAT - 1) / 2] : REL;
                vectors++;
                if (data_mem !== exp_bus) begin
                    miscompares++; $display("FAIL rd_bus n=%0d got %h want %h", n, data_mem, exp_bus);
                end
            end else if (stb !== prev) begin
                w++;
                tb_drv = 1'b0;
            end else if (!tb_drv && w < BEATS) begin
                vectors++;
                if (data_mem !== REL) begin
                    miscompares++; $display("FAIL wr_bus_driven n=%0d got %h want released", n, data_mem);
                end
                tb_drv = 1'b1; tb_dout = wbuf[w];
            end
            prev = stb;
            if (n < D) @(negedge clk);
        end
        if (!rw) for (int k = 0; k < BEATS; k++) mdl[base + k] = wbuf[k];
        tb_drv = 1'b0;
        @(negedge clk);
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL post_idle got busy=%b done=%b want 0 0", busy, done); end
        vectors++; if (data_mem !== REL) begin miscompares++; $display("FAIL post_bus got %h want released", data_mem); end
    endtask

    task automatic test_reset();
        vectors++; if (stb !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++; $display("FAIL reset_outs got stb=%b busy=%b done=%b want 0 0 0", stb, busy, done);
        end
        vectors++; if (data_mem !== REL) begin miscompares++; $display("FAIL reset_bus got %h want released", data_mem); end
        for (int k = 0; k < BEATS; k++) wbuf[k] = $urandom & 32'h7FFF_FFFF;
        wbuf[5] = 32'h1234_5678;
        burst(1'b0, 32'h0, -1, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        vectors++; if (stb !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++; $display("FAIL idle_reset_outs got stb=%b busy=%b done=%b want 0 0 0", stb, busy, done);
        end
        vectors++; if (data_mem !== REL) begin miscompares++; $display("FAIL idle_reset_bus got %h want released", data_mem); end
        vectors++; if (dut.u_array.r_mem[5] !== 32'h1234_5678) begin
            miscompares++; $display("FAIL reset_keeps_array got %h want 12345678", dut.u_array.r_mem[5]);
        end
        rst = 1'b1; req = 1'b1; we_mem = 1'b1;
        @(negedge clk);
        rst = 1'b0; req = 1'b0;
        for (int c = 0; c < LAT + 3; c++) begin
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_with_req c=%0d got busy=%b want 0", c, busy); end
            @(negedge clk);
        end
    endtask

    task automatic test_read();
        for (int k = 0; k < BEATS; k++) wbuf[k] = 32'hA000_0000 + k;
        burst(1'b0, 32'h100, -1, 1'b0);
        burst(1'b1, 32'h100, -1, 1'b0);
    endtask

    task automatic test_unaligned_wrap();
        burst(1'b1, 32'h10C, -1, 1'b0);
        for (int k = 0; k < BEATS; k++) wbuf[k] = $urandom & 32'h7FFF_FFFF;
        burst(1'b0, 32'hFFFF_FF00, -1, 1'b0);
        for (int k = 0; k < BEATS; k++) begin
            vectors++;
            if (dut.u_array.r_mem[12'hFC0 + k] !== wbuf[k]) begin
                miscompares++; $display("FAIL wrap_peek k=%0d got %h want %h", k, dut.u_array.r_mem[12'hFC0 + k], wbuf[k]);
            end
        end
        burst(1'b1, 32'h0000_3F04, -1, 1'b0);
    endtask

    task automatic test_write_read();
        logic [31:0] a;
        for (int k = 0; k < BEATS; k++) wbuf[k] = 32'hC0DE_0000 + k;
        burst(1'b0, 32'h200, -1, 1'b0);
        for (int k = 0; k < BEATS; k++) begin
            vectors++;
            if (dut.u_array.r_mem[32'h80 + k] !== 32'hC0DE_0000 + k) begin
                miscompares++; $display("FAIL wr_peek k=%0d got %h want %h", k, dut.u_array.r_mem[32'h80 + k], 32'hC0DE_0000 + k);
            end
        end
        burst(1'b1, 32'h200, -1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            for (int k = 0; k < BEATS; k++) wbuf[k] = $urandom & 32'h7FFF_FFFF;
            burst(1'b0, a, -1, 1'b0);
            burst(1'b1, {a[31:5], 5'($urandom)}, -1, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        burst(1'b1, 32'h100, LAT + 1 + 6, 1'b0);
        burst(1'b1, 32'h100, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        ntog = 0;
        burst(1'b1, 32'h200, -1, 1'b1);
        burst(1'b1, 32'h10C, -1, 1'b0);
        vectors++; if (ntog !== 2 * BEATS) begin miscompares++; $display("FAIL b2b_toggles got %0d want %0d", ntog, 2 * BEATS); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_read();
        test_unaligned_wrap();
        test_write_read();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
